// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Control FSM that sequences instruction fetch / execute / PC update for a
//   small 8-bit core. Each instruction walks FETCH -> EXEC -> [WAIT_MC] ->
//   ADVANCE. The PC is frozen except in the single ADVANCE cycle. A fetch
//   that waits too long, or reaching the end-of-program address, parks the
//   block in HALT.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active low
//   i_start      level; IDLE -> FETCH, HALT -> IDLE
//   i_pc_value   current PC, compared against EOP_ADDR in ADVANCE
//   i_mem_ready  instruction memory data valid
//   i_is_jump / i_is_branch / i_is_multi   decoder class flags
//   i_alu_zero   branch condition
//   o_ir_load    instruction-register load strobe (the EXEC cycle)
//   o_pc_hold    freeze PC
//   o_pc_jump / o_pc_branch   PC next-value select (ADVANCE only)
//   o_pc_clear   force PC to 0 (IDLE / reset)
//   o_busy / o_halted / o_timeout   status
//
// All outputs decode registered state and flags only.
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [7:0] EOP_ADDR   = 8'hFF,
   parameter logic [3:0] STALL_MAX  = 4'd15,
   parameter int         MUL_CYCLES = 3
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [7:0] i_pc_value,
   input  logic       i_mem_ready,
   input  logic       i_is_jump,
   input  logic       i_is_branch,
   input  logic       i_is_multi,
   input  logic       i_alu_zero,
   output logic       o_ir_load,
   output logic       o_pc_hold,
   output logic       o_pc_jump,
   output logic       o_pc_branch,
   output logic       o_pc_clear,
   output logic       o_busy,
   output logic       o_halted,
   output logic       o_timeout
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_EXEC    = 3'd2;
   localparam logic [2:0] S_WAIT_MC = 3'd3;
   localparam logic [2:0] S_ADVANCE = 3'd4;
   localparam logic [2:0] S_HALT    = 3'd5;

   // WAIT_MC runs count MUL_CYCLES-1 down to 0 inclusive, i.e. MUL_CYCLES cycles
   localparam logic [3:0] MC_LOAD = 4'(MUL_CYCLES - 1);

   logic [2:0] r_state;
   logic [3:0] r_wait_cnt;
   logic [3:0] r_mc_cnt;
   logic       r_jump_q;
   logic       r_br_q;
   logic       r_timeout;

   // jump wins over branch, so the two selects are mutually exclusive
   logic w_br_nxt;
   assign w_br_nxt = i_is_branch & i_alu_zero & ~i_is_jump;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state    <= S_IDLE;
         r_wait_cnt <= 4'd0;
         r_mc_cnt   <= 4'd0;
         r_jump_q   <= 1'b0;
         r_br_q     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state    <= S_FETCH;
                  r_wait_cnt <= 4'd0;
               end
            end
            S_FETCH: begin
               // a ready fetch on the final stall cycle still succeeds
               if (i_mem_ready) begin
                  r_state <= S_EXEC;
               end else if (r_wait_cnt == STALL_MAX) begin
                  r_state   <= S_HALT;
                  r_timeout <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 4'd1;
               end
            end
            S_EXEC: begin
               if (i_is_multi) begin
                  r_state  <= S_WAIT_MC;
                  r_mc_cnt <= MC_LOAD;
               end else begin
                  r_state  <= S_ADVANCE;
                  r_jump_q <= i_is_jump;
                  r_br_q   <= w_br_nxt;
               end
            end
            S_WAIT_MC: begin
               if (r_mc_cnt == 4'd0) begin
                  r_state  <= S_ADVANCE;
                  r_jump_q <= i_is_jump;
                  r_br_q   <= w_br_nxt;
               end else begin
                  r_mc_cnt <= r_mc_cnt - 4'd1;
               end
            end
            S_ADVANCE: begin
               r_wait_cnt <= 4'd0;
               if (i_pc_value == EOP_ADDR) r_state <= S_HALT;
               else                        r_state <= S_FETCH;
            end
            S_HALT: begin
               if (i_start) begin
                  r_state   <= S_IDLE;
                  r_timeout <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   logic w_adv;
   assign w_adv = (r_state == S_ADVANCE);

   assign o_ir_load   = (r_state == S_EXEC);
   assign o_pc_hold   = (r_state == S_FETCH) | (r_state == S_EXEC) |
                        (r_state == S_WAIT_MC) | (r_state == S_HALT);
   assign o_pc_jump   = w_adv & r_jump_q;
   assign o_pc_branch = w_adv & r_br_q;
   assign o_pc_clear  = (r_state == S_IDLE);
   assign o_busy      = (r_state == S_FETCH) | (r_state == S_EXEC) |
                        (r_state == S_WAIT_MC) | w_adv;
   assign o_halted    = (r_state == S_HALT);
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Builds a per-cycle table of {inputs, expected outputs} from an
//   instruction-level description (stall length, class flags, end-of-program)
//   and replays it against the DUT. Directed entries first, then randomized
//   instructions, then hand-written asynchronous reset sequences.
//   Output word order: {ir_load, pc_hold, pc_jump, pc_branch, pc_clear,
//   busy, halted, timeout}.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam int MC = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pc_value = 8'h00;
   logic       mem_ready = 1'b0;
   logic       is_jump = 1'b0, is_branch = 1'b0, is_multi = 1'b0, alu_zero = 1'b0;
   logic       ir_load, pc_hold, pc_jump, pc_branch, pc_clear, busy, halted, timeout;

   pc_sequencer #(.EOP_ADDR(8'hFF), .STALL_MAX(4'd15), .MUL_CYCLES(MC)) dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_pc_value(pc_value),
      .i_mem_ready(mem_ready), .i_is_jump(is_jump), .i_is_branch(is_branch),
      .i_is_multi(is_multi), .i_alu_zero(alu_zero),
      .o_ir_load(ir_load), .o_pc_hold(pc_hold), .o_pc_jump(pc_jump),
      .o_pc_branch(pc_branch), .o_pc_clear(pc_clear), .o_busy(busy),
      .o_halted(halted), .o_timeout(timeout));

   always #5 clk = ~clk;

   logic [7:0] outw;
   assign outw = {ir_load, pc_hold, pc_jump, pc_branch, pc_clear, busy, halted, timeout};

   typedef struct {
      logic       st, mr, j, b, m, z;
      logic [7:0] pc;
      logic [7:0] exp;
      byte        tag;
   } vec_t;

   vec_t q[$];
   int total = 0;
   int bad   = 0;

   // expected output words for each phase of an instruction
   function automatic logic [7:0] w_idle();  return 8'b0000_1000; endfunction
   function automatic logic [7:0] w_fetch(); return 8'b0100_0100; endfunction
   function automatic logic [7:0] w_exec();  return 8'b1100_0100; endfunction
   function automatic logic [7:0] w_wait();  return 8'b0100_0100; endfunction
   function automatic logic [7:0] w_adv(input logic j, input logic br);
      return {2'b00, j, br, 4'b0100};
   endfunction
   function automatic logic [7:0] w_halt(input logic t);
      return {7'b0100_001, t};
   endfunction

   function automatic logic rb(); return 1'($urandom_range(0, 1)); endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s[%0d] got=%b want=%b", nm, idx, got, exp);
      end
   endtask

   task automatic push(input logic st, mr, j, b, m, z, input logic [7:0] pc,
                       input logic [7:0] ex, input byte tg);
      vec_t v;
      v.st = st; v.mr = mr; v.j = j; v.b = b; v.m = m; v.z = z;
      v.pc = pc; v.exp = ex; v.tag = tg;
      q.push_back(v);
   endtask

   // n quiet IDLE cycles, then one with start=1
   task automatic gen_idle(input int n);
      for (int k = 0; k < n; k++)
         push(1'b0, rb(), rb(), rb(), rb(), rb(), 8'($urandom), w_idle(), "I");
      push(1'b1, rb(), rb(), rb(), rb(), rb(), 8'($urandom), w_idle(), "I");
   endtask

   // n HALT cycles with start=0, then one with start=1 (next cycle is IDLE)
   task automatic gen_halt(input int n, input logic t);
      for (int k = 0; k < n; k++)
         push(1'b0, rb(), rb(), rb(), rb(), rb(), 8'($urandom), w_halt(t), "H");
      push(1'b1, rb(), rb(), rb(), rb(), rb(), 8'($urandom), w_halt(t), "H");
   endtask

   // One instruction starting at FETCH. stall = number of not-ready fetch
   // cycles; 16 or more means the fetch times out after 16 cycles.
   task automatic gen_instr(input int stall, input logic j, b, m, z, eop, input logic noise,
                            output logic hlt, output logic tmo);
      hlt = 1'b0; tmo = 1'b0;
      if (stall >= 16) begin
         for (int k = 0; k < 16; k++)
            push(noise & rb(), 1'b0, rb(), rb(), rb(), rb(), 8'($urandom), w_fetch(), "F");
         hlt = 1'b1; tmo = 1'b1;
         return;
      end
      for (int k = 0; k < stall; k++)
         push(noise & rb(), 1'b0, rb(), rb(), rb(), rb(), 8'($urandom), w_fetch(), "F");
      push(noise & rb(), 1'b1, rb(), rb(), rb(), rb(), 8'($urandom), w_fetch(), "F");
      if (m) begin
         // flags in EXEC are irrelevant except is_multi; only the last WAIT_MC cycle counts
         push(noise & rb(), rb(), rb(), rb(), 1'b1, rb(), 8'($urandom), w_exec(), "E");
         for (int k = 0; k < MC - 1; k++)
            push(noise & rb(), rb(), rb(), rb(), rb(), rb(), 8'($urandom), w_wait(), "W");
         push(noise & rb(), rb(), j, b, rb(), z, 8'($urandom), w_wait(), "W");
      end else begin
         push(noise & rb(), rb(), j, b, 1'b0, z, 8'($urandom), w_exec(), "E");
      end
      push(noise & rb(), rb(), rb(), rb(), rb(), rb(),
           eop ? 8'hFF : 8'($urandom_range(0, 254)), w_adv(j, b & z & ~j), "A");
      hlt = eop;
   endtask

   task automatic apply_all(input string nm);
      for (int i = 0; i < q.size(); i++) begin
         @(negedge clk);
         chk($sformatf("%s_%c", nm, q[i].tag), i, outw, q[i].exp);
         start = q[i].st; mem_ready = q[i].mr; is_jump = q[i].j;
         is_branch = q[i].b; is_multi = q[i].m; alu_zero = q[i].z;
         pc_value = q[i].pc;
      end
      q.delete();
   endtask

   initial begin
      logic h, t;
      // async reset, checked before any clock edge
      #1 rst_n = 1'b0;
      #1 chk("reset_out", 0, outw, w_idle());
      @(negedge clk);
      chk("reset_hold", 0, outw, w_idle());
      rst_n = 1'b1;

      // ---- directed table ----
      gen_idle(3);                                              // stays IDLE until start
      for (int k = 0; k < 3; k++) gen_instr(0, 0, 0, 0, 0, 0, 0, h, t); // straight line
      gen_instr(0, 0, 1, 0, 1, 0, 0, h, t);                     // branch taken
      gen_instr(0, 0, 1, 0, 0, 0, 0, h, t);                     // branch not taken
      gen_instr(0, 1, 1, 0, 1, 0, 0, h, t);                     // jump beats branch
      gen_instr(0, 1, 0, 1, 0, 0, 0, h, t);                     // multi-cycle jump
      gen_instr(0, 0, 1, 1, 1, 0, 0, h, t);                     // multi-cycle branch
      gen_instr(15, 0, 0, 0, 0, 0, 0, h, t);                    // ready on the 16th cycle
      gen_instr(16, 0, 0, 0, 0, 0, 1, h, t);                    // timeout
      gen_halt(2, 1'b1);
      gen_idle(1);
      gen_instr(2, 0, 0, 0, 0, 1, 1, h, t);                     // end of program, start noise
      gen_halt(1, 1'b0);
      gen_idle(0);
      gen_instr(0, 0, 0, 0, 0, 0, 0, h, t);
      apply_all("dir");

      // ---- randomized instructions ----
      for (int n = 0; n < 150; n++) begin
         int st;
         st = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 17)) : int'($urandom_range(0, 3));
         gen_instr(st, rb(), rb(), rb(), rb(), ($urandom_range(0, 11) == 0), 1'b1, h, t);
         if (h) begin
            gen_halt(int'($urandom_range(0, 3)), t);
            gen_idle(int'($urandom_range(0, 2)));
         end
      end
      apply_all("rnd");

      // ---- async reset mid-WAIT_MC ----
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      start = 1'b1; mem_ready = 1'b1; is_multi = 1'b1; is_jump = 1'b1;
      is_branch = 1'b0; alu_zero = 1'b0; pc_value = 8'h10;
      @(negedge clk); start = 1'b0;
      chk("mc_fetch", 0, outw, w_fetch());
      @(negedge clk); chk("mc_exec", 0, outw, w_exec());
      @(negedge clk); chk("mc_wait", 0, outw, w_wait());
      @(posedge clk); #2 rst_n = 1'b0;
      #1 chk("rst_mid_wait", 0, outw, w_idle());
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk); chk("post_rst_idle", k, outw, w_idle());
      end

      // ---- async reset in ADVANCE drops the pending jump ----
      start = 1'b1; is_multi = 1'b0; is_jump = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("adv_fetch", 0, outw, w_fetch());
      @(negedge clk); chk("adv_exec", 0, outw, w_exec());
      @(negedge clk); chk("adv_jump", 0, outw, w_adv(1'b1, 1'b0));
      #2 rst_n = 1'b0;
      #1 chk("rst_in_adv", 0, outw, w_idle());
      @(negedge clk); rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); chk("post_adv_idle", k, outw, w_idle());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter EOP_ADDR, default 8'hFF: end-of-program PC value.
REQ-002 Parameter STALL_MAX, default 4'd15: fetch-wait limit in cycles before timeout.
REQ-003 Parameter MUL_CYCLES, default 3 (legal 1..15): extra hold cycles for a multi-cycle instruction.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; begins execution from IDLE, or returns HALT to IDLE.
REQ-007 pc_value  in  8  current program-counter value.
REQ-008 mem_ready  in  1  instruction memory data valid this cycle.
REQ-009 is_jump, is_branch, is_multi  in  1 each  decoder class flags for the instruction in IR.
REQ-010 alu_zero  in  1  branch condition from ALU.
REQ-011 ir_load  out  1  one-cycle instruction-register load strobe.
REQ-012 pc_hold  out  1  freeze PC.
REQ-013 pc_jump, pc_branch  out  1 each  PC next-value select.
REQ-014 pc_clear  out  1  drive PC to 8'h00.
REQ-015 busy, halted, timeout  out  1 each  status.

Function
REQ-016 FSM states IDLE, FETCH, EXEC, WAIT_MC, ADVANCE, HALT; every output is a function of registered state and registered flags only, with no input-to-output combinational path.
REQ-017 IDLE: pc_clear=1, pc_hold=0, all other outputs 0; start=1 -> FETCH.
REQ-018 FETCH: pc_hold=1, busy=1; a 4-bit wait counter clears on entry and increments each cycle with mem_ready=0.
REQ-019 FETCH with mem_ready=1: ir_load=1 for the following cycle; next state is EXEC.
REQ-020 FETCH with mem_ready=0 and counter==STALL_MAX: next state is HALT, and timeout is set.
REQ-021 FETCH: mem_ready=1 in the same cycle the counter reaches STALL_MAX -> the fetch succeeds and no timeout is raised.
REQ-022 EXEC is 1 cycle with pc_hold=1.
REQ-023 EXEC, is_multi=1: next state is WAIT_MC with the down-counter loaded to MUL_CYCLES-1.
REQ-024 EXEC, is_multi=0: next state is ADVANCE.
REQ-025 WAIT_MC: pc_hold=1; the down-counter decrements each cycle; on count 0 the next state is ADVANCE; the state lasts exactly MUL_CYCLES cycles.
REQ-026 On the last EXEC/WAIT_MC cycle, register jump_q=is_jump and br_q=is_branch & alu_zero & ~is_jump, so jump has priority over branch.
REQ-027 ADVANCE is exactly 1 cycle: pc_hold=0, pc_jump=jump_q, pc_branch=br_q, busy=1.
REQ-028 ADVANCE exit: if pc_value==EOP_ADDR the next state is HALT, else FETCH.
REQ-029 HALT: pc_hold=1, halted=1, busy=0; start=1 -> IDLE.
REQ-030 timeout is sticky: it is set only on a FETCH timeout and is cleared only on the HALT->IDLE transition.
REQ-031 start is ignored in FETCH, EXEC, WAIT_MC and ADVANCE.
REQ-032 pc_hold=0 in at most one cycle per instruction (the ADVANCE cycle); minimum instruction period is 3 cycles (FETCH with mem_ready=1, EXEC, ADVANCE).
REQ-033 pc_jump and pc_branch are never asserted together and are 0 outside ADVANCE.

Reset
REQ-034 reset=0 asynchronously forces state IDLE, clears both counters, jump_q, br_q and timeout.
REQ-035 During reset: pc_clear=1, pc_hold=0, all other outputs 0.
REQ-036 Reset asserted mid-instruction, including in ADVANCE, drops any pending jump or branch.
REQ-037 After reset deassertion the block stays in IDLE until start=1.

Verification
REQ-038 Straight-line: reset, start, mem_ready tied 1, all flags 0 -> pc_hold low one cycle in every 3; ir_load pulses once per 3 cycles; pc_jump and pc_branch stay 0.
REQ-039 Branch: is_branch=1, alu_zero=1 -> pc_branch=1 in ADVANCE only; repeat with alu_zero=0 -> pc_branch stays 0; with is_jump=is_branch=1 -> pc_jump=1 and pc_branch=0.
REQ-040 Multi-cycle: is_multi=1, MUL_CYCLES=3 -> 3 WAIT_MC cycles between EXEC and ADVANCE; instruction period is 6 cycles.
REQ-041 Timeout: mem_ready held 0 -> HALT entered after 16 FETCH cycles with timeout=1 and halted=1; start -> IDLE with timeout=0; separately, mem_ready=1 on cycle 16 -> no timeout.
REQ-042 End of program: pc_value=8'hFF during ADVANCE -> HALT next cycle; start held high in FETCH has no effect.
REQ-043 Async reset: drive reset low mid-WAIT_MC, between clock edges -> pc_clear=1 immediately; after release no pc_jump/pc_branch until a fresh start.
